// File: rtl/sao_offset_apply_n8.sv
// SAO offset application: 8 pixels per beat through a 2-stage stallable
// valid/ready pipeline, with the offset table loaded once per CTB.
module sao_offset_apply_n8 #(
    parameter int PIX8          = 8,
    parameter int BIT_DEPTH     = 8,
    parameter int N_BO_TYPE     = 5,
    parameter int DIFF_CLIP_BIT = 4
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [1:0]                            cfg_type,
    input  logic [4:0]                            cfg_band,
    input  logic [3:0][DIFF_CLIP_BIT:0]           cfg_off,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    input  logic                                  pix_last,
    input  logic [PIX8-1:0][BIT_DEPTH-1:0]        pix_in,
    input  logic [PIX8-1:0][N_BO_TYPE-1:0]        cate,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [PIX8-1:0][BIT_DEPTH-1:0]        pix_out
);

    // state | meaning
    // IDLE  | waiting for an offset table
    // RUN   | table latched, accepting pixel beats
    // DRAIN | last beat taken, flushing the pipeline
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                             state_q, state_d;
    logic [1:0]                         type_q, type_d;
    logic [4:0]                         band_q, band_d;
    logic [3:0][DIFF_CLIP_BIT:0]        off_q, off_d;

    logic                               s1_valid_q, s1_valid_d;
    logic                               s1_last_q, s1_last_d;
    logic [PIX8-1:0][BIT_DEPTH-1:0]     s1_pix_q, s1_pix_d;
    logic [PIX8-1:0][DIFF_CLIP_BIT:0]   s1_off_q, s1_off_d;

    logic                               out_valid_q, out_valid_d;
    logic                               out_last_q, out_last_d;
    logic [PIX8-1:0][BIT_DEPTH-1:0]     pix_out_q, pix_out_d;

    logic                               s2_adv, s1_adv, cfg_acc, pix_acc;
    logic [PIX8-1:0][N_BO_TYPE-1:0]     bo_k, eo_k;
    logic [PIX8-1:0][DIFF_CLIP_BIT:0]   off_sel;
    logic [PIX8-1:0][BIT_DEPTH+1:0]     sum;
    logic [PIX8-1:0][BIT_DEPTH-1:0]     clip;

    // A stage may load when the stage after it is empty or emptying this cycle.
    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign cfg_ready = (state_q == IDLE);
    assign pix_ready = (state_q == RUN) && s1_adv;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign pix_acc   = pix_valid && pix_ready;

    always_comb begin
        for (int i = 0; i < PIX8; i++) begin
            bo_k[i]    = cate[i] - N_BO_TYPE'(band_q);
            eo_k[i]    = cate[i] - N_BO_TYPE'(1);
            off_sel[i] = '0;
            case (type_q)
                2'd1: if (bo_k[i] < N_BO_TYPE'(4)) off_sel[i] = off_q[bo_k[i][1:0]];
                2'd2: if (cate[i] >= N_BO_TYPE'(1) && cate[i] <= N_BO_TYPE'(4))
                          off_sel[i] = off_q[eo_k[i][1:0]];
                default: ;
            endcase
        end
    end

    // Two guard bits: the top one flags underflow, the next one overflow.
    always_comb begin
        for (int i = 0; i < PIX8; i++) begin
            sum[i] = {2'b00, s1_pix_q[i]}
                   + {{(BIT_DEPTH + 1 - DIFF_CLIP_BIT){s1_off_q[i][DIFF_CLIP_BIT]}}, s1_off_q[i]};
            if (sum[i][BIT_DEPTH+1])
                clip[i] = '0;
            else if (sum[i][BIT_DEPTH])
                clip[i] = '1;
            else
                clip[i] = sum[i][BIT_DEPTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        band_d      = band_q;
        off_d       = off_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_pix_d    = s1_pix_q;
        s1_off_d    = s1_off_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pix_out_d   = pix_out_q;

        case (state_q)
            IDLE: if (cfg_acc) begin
                type_d  = cfg_type;
                band_d  = cfg_band;
                off_d   = cfg_off;
                state_d = RUN;
            end
            RUN:     if (pix_acc && pix_last) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !out_valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (s1_adv) s1_valid_d = pix_acc;
        if (pix_acc) begin
            s1_pix_d  = pix_in;
            s1_off_d  = off_sel;
            s1_last_d = pix_last;
        end

        if (s2_adv) out_valid_d = s1_valid_q;
        if (s2_adv && s1_valid_q) begin
            pix_out_d  = clip;
            out_last_d = s1_last_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            type_q      <= '0;
            band_q      <= '0;
            off_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_pix_q    <= '0;
            s1_off_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pix_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            band_q      <= band_d;
            off_q       <= off_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_pix_q    <= s1_pix_d;
            s1_off_q    <= s1_off_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pix_out_q   <= pix_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign pix_out   = pix_out_q;

endmodule
